// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the IF/ID stage: FSM encodings, NOP word,
// counter limits and a saturating increment helper.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] NOP_PCP4  = 32'h0000_0000;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // Event counters stick at all-ones instead of wrapping back to zero
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detector: flags when the load in EX writes a register the
// instruction in ID is about to read.
module hazard_detect (
  input  logic       x_memRead,
  input  logic [4:0] x_rt,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  output logic       hazard
);

  logic w_rtNonZero;
  logic w_match;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_rtNonZero = (x_rt != 5'd0);
  assign w_match     = (x_rt == d_rs) || (x_rt == d_rt);
  assign hazard      = x_memRead && w_rtNonZero && w_match;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush, a small FSM
// recording the last edge's action, and saturating stall/flush counters.
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pcp4,
  input  logic [31:0] f_instr,
  input  logic        x_memRead,
  input  logic [4:0]  x_rt,
  input  logic        m_branchTaken,
  output logic [31:0] d_pcp4,
  output logic [31:0] d_instr,
  output logic [4:0]  d_rs,
  output logic [4:0]  d_rt,
  output logic [4:0]  d_rd,
  output logic [31:0] d_seInstr16,
  output logic [5:0]  d_ctlIn,
  output logic        pcWrite,
  output logic        d_bubble,
  output logic [1:0]  d_state,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  logic [31:0] r_pcp4;
  logic [31:0] r_instr;
  state_t      r_state;
  logic [15:0] r_stallCount;
  logic [15:0] r_flushCount;

  state_t      w_nextState;
  logic        w_hazard;
  logic        w_pcWrite;
  logic        w_bubble;

  assign d_pcp4      = r_pcp4;
  assign d_instr     = r_instr;
  assign d_rs        = r_instr[25:21];
  assign d_rt        = r_instr[20:16];
  assign d_rd        = r_instr[15:11];
  assign d_ctlIn     = r_instr[31:26];
  assign d_seInstr16 = {{16{r_instr[15]}}, r_instr[15:0]};

  hazard_detect u_hazard (
    .x_memRead (x_memRead),
    .x_rt      (x_rt),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .hazard    (w_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush outranks stall: the stalled instruction is on the wrong path anyway
  always_comb begin
    w_nextState = ST_RUN;
    w_pcWrite   = 1'b1;
    w_bubble    = 1'b0;
    if (m_branchTaken) begin
      w_nextState = ST_FLUSH;
      w_bubble    = 1'b1;
    end else if (w_hazard) begin
      w_nextState = ST_STALL;
      w_pcWrite   = 1'b0;
      w_bubble    = 1'b1;
    end
  end

  assign pcWrite  = w_pcWrite;
  assign d_bubble = w_bubble;
  assign d_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcp4  <= NOP_PCP4;
      r_instr <= NOP_INSTR;
    end else begin
      case (w_nextState)
        ST_FLUSH: begin
          r_pcp4  <= NOP_PCP4;
          r_instr <= NOP_INSTR;
        end
        ST_STALL: begin
          r_pcp4  <= r_pcp4;
          r_instr <= r_instr;
        end
        default: begin
          r_pcp4  <= f_pcp4;
          r_instr <= f_instr;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCount <= 16'd0;
      r_flushCount <= 16'd0;
    end else begin
      if (w_nextState == ST_STALL) begin
        r_stallCount <= satInc(r_stallCount);
      end
      if (w_nextState == ST_FLUSH) begin
        r_flushCount <= satInc(r_flushCount);
      end
    end
  end

  assign stallCount = r_stallCount;
  assign flushCount = r_flushCount;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a vector table for the main pipeline flow
// plus hand sequences for reset, async reset mid-stall and counter saturation.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] f_pcp4;
  logic [31:0] f_instr;
  logic        x_memRead;
  logic [4:0]  x_rt;
  logic        m_branchTaken;
  logic [31:0] d_pcp4;
  logic [31:0] d_instr;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [4:0]  d_rd;
  logic [31:0] d_seInstr16;
  logic [5:0]  d_ctlIn;
  logic        pcWrite;
  logic        d_bubble;
  logic [1:0]  d_state;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic        memRead;
    logic [4:0]  xRt;
    logic        branch;
    logic        expPcWrite;
    logic        expBubble;
    logic [31:0] expInstr;
    logic [31:0] expPcp4;
    logic [1:0]  expState;
    logic [15:0] expStall;
    logic [15:0] expFlush;
    logic [4:0]  expRs;
    logic [4:0]  expRt;
    logic [4:0]  expRd;
    logic [31:0] expSe;
    logic [5:0]  expCtl;
  } vec_t;

  vec_t vecs[9];

  if_id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .f_pcp4        (f_pcp4),
    .f_instr       (f_instr),
    .x_memRead     (x_memRead),
    .x_rt          (x_rt),
    .m_branchTaken (m_branchTaken),
    .d_pcp4        (d_pcp4),
    .d_instr       (d_instr),
    .d_rs          (d_rs),
    .d_rt          (d_rt),
    .d_rd          (d_rd),
    .d_seInstr16   (d_seInstr16),
    .d_ctlIn       (d_ctlIn),
    .pcWrite       (pcWrite),
    .d_bubble      (d_bubble),
    .d_state       (d_state),
    .stallCount    (stallCount),
    .flushCount    (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pcp4, input logic [31:0] instr,
                               input logic memRead, input logic [4:0] xRt, input logic branch);
    f_pcp4        = pcp4;
    f_instr       = instr;
    x_memRead     = memRead;
    x_rt          = xRt;
    m_branchTaken = branch;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    stepClock();
    stepClock();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    f_pcp4 = 32'h0; f_instr = 32'h0; x_memRead = 1'b0; x_rt = 5'd0; m_branchTaken = 1'b0;

    // Pipeline flow: stream, load-use stall, flush beating stall, r0 target, repeated stall, flush
    vecs[0] = '{32'h4,  32'h8C22_0004, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h8C22_0004, 32'h4,  2'b00, 16'd0, 16'd0, 5'd1, 5'd2, 5'd0,  32'h0000_0004, 6'h23};
    vecs[1] = '{32'h8,  32'h0043_0820, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 32'h8C22_0004, 32'h4,  2'b01, 16'd1, 16'd0, 5'd1, 5'd2, 5'd0,  32'h0000_0004, 6'h23};
    vecs[2] = '{32'h8,  32'h0043_0820, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 32'h0043_0820, 32'h8,  2'b00, 16'd1, 16'd0, 5'd2, 5'd3, 5'd1,  32'h0000_0820, 6'h00};
    vecs[3] = '{32'hC,  32'hAC65_FFF0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0,  2'b10, 16'd1, 16'd1, 5'd0, 5'd0, 5'd0,  32'h0,         6'h00};
    vecs[4] = '{32'h10, 32'hAC65_FFF0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAC65_FFF0, 32'h10, 2'b00, 16'd1, 16'd1, 5'd3, 5'd5, 5'd31, 32'hFFFF_FFF0, 6'h2B};
    vecs[5] = '{32'h14, 32'h0,         1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 32'hAC65_FFF0, 32'h10, 2'b01, 16'd2, 16'd1, 5'd3, 5'd5, 5'd31, 32'hFFFF_FFF0, 6'h2B};
    vecs[6] = '{32'h14, 32'h0,         1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 32'hAC65_FFF0, 32'h10, 2'b01, 16'd3, 16'd1, 5'd3, 5'd5, 5'd31, 32'hFFFF_FFF0, 6'h2B};
    vecs[7] = '{32'h14, 32'h0,         1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0,         32'h0,  2'b10, 16'd3, 16'd2, 5'd0, 5'd0, 5'd0,  32'h0,         6'h00};
    vecs[8] = '{32'h18, 32'h8C22_0004, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h8C22_0004, 32'h18, 2'b00, 16'd3, 16'd2, 5'd1, 5'd2, 5'd0,  32'h0000_0004, 6'h23};

    // Reset with random data inputs: everything cleared, PC free to advance
    rst = 1'b1;
    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
    stepClock();
    applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
    checkOutput("rst_instr", d_instr, 32'h0);
    checkOutput("rst_pcp4", d_pcp4, 32'h0);
    checkOutput("rst_se", d_seInstr16, 32'h0);
    checkOutput("rst_fields", {d_rs, d_rt, d_rd, d_ctlIn}, 32'h0);
    checkOutput("rst_state", {30'd0, d_state}, 32'h0);
    checkOutput("rst_counts", {stallCount, flushCount}, 32'h0);
    checkOutput("rst_pcWrite", {31'd0, pcWrite}, 32'h1);
    checkOutput("rst_bubble", {31'd0, d_bubble}, 32'h0);
    stepClock();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].pcp4, vecs[i].instr, vecs[i].memRead, vecs[i].xRt, vecs[i].branch);
      checkOutput($sformatf("v%0d_pcWrite", i), {31'd0, pcWrite}, {31'd0, vecs[i].expPcWrite});
      checkOutput($sformatf("v%0d_bubble", i), {31'd0, d_bubble}, {31'd0, vecs[i].expBubble});
      stepClock();
      checkOutput($sformatf("v%0d_instr", i), d_instr, vecs[i].expInstr);
      checkOutput($sformatf("v%0d_pcp4", i), d_pcp4, vecs[i].expPcp4);
      checkOutput($sformatf("v%0d_state", i), {30'd0, d_state}, {30'd0, vecs[i].expState});
      checkOutput($sformatf("v%0d_stallCount", i), {16'd0, stallCount}, {16'd0, vecs[i].expStall});
      checkOutput($sformatf("v%0d_flushCount", i), {16'd0, flushCount}, {16'd0, vecs[i].expFlush});
      checkOutput($sformatf("v%0d_rs_rt_rd", i), {17'd0, d_rs, d_rt, d_rd}, {17'd0, vecs[i].expRs, vecs[i].expRt, vecs[i].expRd});
      checkOutput($sformatf("v%0d_se", i), d_seInstr16, vecs[i].expSe);
      checkOutput($sformatf("v%0d_ctl", i), {26'd0, d_ctlIn}, {26'd0, vecs[i].expCtl});
    end

    // Async reset in the middle of a stall clears state without a clock edge
    applyStimulus(32'h20, 32'h8C22_0004, 1'b0, 5'd0, 1'b0);
    stepClock();
    applyStimulus(32'h24, 32'h0043_0820, 1'b1, 5'd1, 1'b0);
    stepClock();
    checkOutput("midstall_state", {30'd0, d_state}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_instr", d_instr, 32'h0);
    checkOutput("async_rst_state", {30'd0, d_state}, 32'h0);
    checkOutput("async_rst_stall", {16'd0, stallCount}, 32'h0);
    checkOutput("async_rst_flush", {16'd0, flushCount}, 32'h0);
    rst = 1'b0;
    applyStimulus(32'h28, 32'h0043_0820, 1'b1, 5'd1, 1'b0);
    checkOutput("post_rst_pcWrite", {31'd0, pcWrite}, 32'h1);
    stepClock();
    checkOutput("post_rst_instr", d_instr, 32'h0043_0820);
    checkOutput("post_rst_pcp4", d_pcp4, 32'h28);
    checkOutput("post_rst_state", {30'd0, d_state}, 32'h0);

    // Saturation: drive 65534 stalls to reach FFFE, then three more stay at FFFF
    doReset();
    applyStimulus(32'h4, 32'h8C22_0004, 1'b0, 5'd0, 1'b0);
    stepClock();
    applyStimulus(32'h8, 32'h0, 1'b1, 5'd1, 1'b0);
    for (int n = 0; n < 65534; n++) begin
      stepClock();
    end
    checkOutput("sat_pre", {16'd0, stallCount}, 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      stepClock();
      checkOutput($sformatf("sat_%0d", k), {16'd0, stallCount}, 32'h0000_FFFF);
    end
    checkOutput("sat_held_instr", d_instr, 32'h8C22_0004);
    checkOutput("sat_state", {30'd0, d_state}, 32'h1);
    checkOutput("sat_flush", {16'd0, flushCount}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
